// File: rtl/reg_scoreboard_pkg.sv
// Shared register-class encodings and the register-id mapping used by the
// issue scoreboard; the encoding matches the register file select fields.
package reg_scoreboard_pkg;

  typedef enum logic [1:0] {
    SPEC_GPR = 2'b00,
    SPEC_SP  = 2'b01,
    SPEC_IH  = 2'b10,
    SPEC_T   = 2'b11
  } spec_e;

  localparam int unsigned NUM_SB_REGS = 11;
  localparam int unsigned REG_ID_W    = 4;

  // GPRs occupy ids 0-7; the special registers follow. idx is ignored for them.
  function automatic logic [REG_ID_W-1:0] reg_id(input logic [1:0] spec,
                                                 input logic [2:0] idx);
    logic [REG_ID_W-1:0] id;
    id = '0;
    case (spec_e'(spec))
      SPEC_GPR: id = {1'b0, idx};
      SPEC_SP:  id = REG_ID_W'(8);
      SPEC_IH:  id = REG_ID_W'(9);
      SPEC_T:   id = REG_ID_W'(10);
      default:  id = '0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/reg_scoreboard_ctr.sv
// One per-register pending-write counter: increments on issue, decrements on
// writeback, clears on flush, and flags writebacks that find nothing pending.
module sb_pending_ctr #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_ok, inc_ok;

  always_comb begin
    dec_ok    = dec && (count_q != '0);
    // A full counter only accepts an increment paired with a release.
    inc_ok    = inc && (dec_ok || (count_q != CNT_W'(MAX_INFLIGHT)));
    underflow = dec && (count_q == '0);
    count_d   = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc_ok && !dec_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller: stalls decode on RAW hazards and pending-count
// saturation, releases registers on writeback, and counts stall cycles.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned STALL_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   id_valid,
  input  logic                   id_rd1_en,
  input  logic [1:0]             id_rd1_spec,
  input  logic [2:0]             id_rd1_idx,
  input  logic                   id_rd2_en,
  input  logic [2:0]             id_rd2_idx,
  input  logic                   id_wr_en,
  input  logic [1:0]             id_wr_spec,
  input  logic [2:0]             id_wr_idx,
  input  logic                   wb_valid,
  input  logic [1:0]             wb_spec,
  input  logic [2:0]             wb_idx,
  input  logic                   flush,
  input  logic                   perf_clr,
  output logic                   id_stall,
  output logic                   id_issue,
  output logic [NUM_SB_REGS-1:0] busy_vec,
  output logic [STALL_W-1:0]     stall_cnt,
  output logic                   err_underflow
);

  logic [CNT_W-1:0]       count [NUM_SB_REGS];
  logic [CNT_W-1:0]       eff   [NUM_SB_REGS];
  logic [NUM_SB_REGS-1:0] busy, wb_hit, inc_vec, uf_vec;
  logic [REG_ID_W-1:0]    rd1_id, wr_id, wb_id;
  logic                   haz1, haz2, hazw;
  logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                   err_underflow_q, err_underflow_d;

  always_comb begin
    rd1_id = reg_id(id_rd1_spec, id_rd1_idx);
    wr_id  = reg_id(id_wr_spec, id_wr_idx);
    wb_id  = reg_id(wb_spec, wb_idx);
    // Same-cycle writeback counts as released: the register file writes on negedge.
    for (int unsigned r = 0; r < NUM_SB_REGS; r++) begin
      wb_hit[r] = wb_valid && (wb_id == REG_ID_W'(r));
      eff[r]    = count[r] - ((wb_hit[r] && busy[r]) ? CNT_W'(1) : '0);
    end
    haz1     = id_rd1_en && (eff[rd1_id] != '0);
    haz2     = id_rd2_en && (eff[{1'b0, id_rd2_idx}] != '0);
    hazw     = id_wr_en && (eff[wr_id] == CNT_W'(MAX_INFLIGHT));
    id_stall = id_valid && (haz1 || haz2 || hazw || flush);
    id_issue = id_valid && !id_stall;
    for (int unsigned r = 0; r < NUM_SB_REGS; r++) begin
      inc_vec[r] = id_issue && id_wr_en && (wr_id == REG_ID_W'(r));
    end
  end

  for (genvar g = 0; g < NUM_SB_REGS; g++) begin : g_ctr
    sb_pending_ctr #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_ctr (
      .clk       (CLK),
      .rst_n     (RST),
      .inc       (inc_vec[g]),
      .dec       (wb_hit[g]),
      .clr       (flush),
      .count     (count[g]),
      .busy      (busy[g]),
      .underflow (uf_vec[g])
    );
  end

  always_comb begin
    err_underflow_d = err_underflow_q || (|uf_vec);
    stall_cnt_d     = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if (id_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q     <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign busy_vec      = busy;
  assign stall_cnt     = stall_cnt_q;
  assign err_underflow = err_underflow_q;

endmodule
